// File: rtl/wb_stage_arb.sv
// Writeback stage: merges the in-order result with NUM_LATE late producers through a FIFO.
// Uses round-robin late arbitration and a starvation guard. Define WB_LOAD_ALIGN_EN for load alignment and extension.
module wb_stage_arb #(
  parameter int XLEN         = 32,
  parameter int NUM_LATE     = 2,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          opr_res,
  input  logic [XLEN-1:0]          lsu_rdata,
  input  logic [XLEN-1:0]          pc4,
  input  logic [4:0]               rd,
  input  logic                     rf_en,
  input  logic [1:0]               wb_sel,
  input  logic [2:0]               lsu_op,
  input  logic [1:0]               lsu_off,
  input  logic [NUM_LATE-1:0]      late_valid,
  output logic [NUM_LATE-1:0]      late_ready,
  input  logic [NUM_LATE*XLEN-1:0] late_data,
  input  logic [NUM_LATE*5-1:0]    late_rd,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic                     wb_src_late
);

  localparam int AW  = $clog2(DEPTH);
  localparam int RRW = (NUM_LATE > 1) ? $clog2(NUM_LATE) : 1;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);

  logic [XLEN-1:0] fifo_data_mem [DEPTH];
  logic [4:0]      fifo_rd_mem   [DEPTH];

  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]     count_q, count_d;
  logic [RRW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            src_late_q, src_late_d;

  logic [XLEN-1:0] late_data_arr [NUM_LATE];
  logic [4:0]      late_rd_arr   [NUM_LATE];
  logic            grant_any;
  logic [RRW-1:0]  grant_idx;
  logic [RRW:0]    scan_sum;
  logic            fifo_empty, fifo_full;
  logic            main_xfer, main_wr, pop, push;
  logic [XLEN-1:0] load_data, main_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LATE; gi++) begin : g_chan
      assign late_data_arr[gi] = late_data[gi*XLEN +: XLEN];
      assign late_rd_arr[gi]   = late_rd[gi*5 +: 5];
      assign late_ready[gi]    = rst_n & grant_any & (grant_idx == RRW'(gi));
    end
  endgenerate

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(DEPTH));

  // Search starts at rr_ptr and wraps; a full FIFO blocks every grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    for (int k = 0; k < NUM_LATE; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (RRW+1)'(k);
      if (scan_sum >= (RRW+1)'(NUM_LATE))
        scan_sum = scan_sum - (RRW+1)'(NUM_LATE);
      if (!grant_any && late_valid[scan_sum[RRW-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_sum[RRW-1:0];
      end
    end
    if (fifo_full)
      grant_any = 1'b0;
  end

`ifdef WB_LOAD_ALIGN_EN
  logic [XLEN-1:0] load_shift;
  assign load_shift = lsu_rdata >> {lsu_off, 3'b000};

  always_comb begin
    load_data = load_shift;
    case (lsu_op)
      3'b000:  load_data = {{(XLEN-8){load_shift[7]}}, load_shift[7:0]};
      3'b001:  load_data = {{(XLEN-16){load_shift[15]}}, load_shift[15:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, load_shift[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, load_shift[15:0]};
      default: load_data = load_shift;
    endcase
  end
`else
  logic unused_load_ctrl;
  assign unused_load_ctrl = ^{lsu_op, lsu_off};
  assign load_data        = lsu_rdata;
`endif

  always_comb begin
    case (wb_sel)
      2'd1:    main_data = load_data;
      2'd2:    main_data = pc4;
      default: main_data = opr_res;
    endcase
  end

  // Throttling the main path for one cycle guarantees the FIFO head drains.
  assign in_ready  = (starve_q != SW'(STARVE_LIMIT));
  assign main_xfer = in_valid & in_ready;
  assign main_wr   = main_xfer & rf_en & (rd != 5'd0);
  assign pop       = ~fifo_empty & ~main_wr;
  assign push      = grant_any & (late_rd_arr[grant_idx] != 5'd0);

  always_comb begin
    wptr_d   = wptr_q + AW'(push);
    rptr_d   = rptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    rr_ptr_d = rr_ptr_q;
    if (grant_any)
      rr_ptr_d = (grant_idx == RRW'(NUM_LATE-1)) ? '0 : grant_idx + 1'b1;
    starve_d = (fifo_empty || pop) ? '0 : starve_q + 1'b1;
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    src_late_d = 1'b0;
    if (main_wr) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = rd;
      rf_wdata_d = main_data;
    end else if (pop) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = fifo_rd_mem[rptr_q];
      rf_wdata_d = fifo_data_mem[rptr_q];
      src_late_d = 1'b1;
    end
  end

  // Storage has no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wptr_q] <= late_data_arr[grant_idx];
      fifo_rd_mem[wptr_q]   <= late_rd_arr[grant_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rr_ptr_q   <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      src_late_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      src_late_q <= src_late_d;
    end
  end

  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign wb_src_late = src_late_q;

endmodule

// File: tb/tb_wb_stage_arb.sv
// Self-checking bench for wb_stage_arb: table vectors, directed corner sequences and random traffic
// compared against a queue-based reference model of the writeback rules.
`timescale 1ns/1ps
module tb_wb_stage_arb;
  localparam int XLEN = 32;
  localparam int NL = 2;
  localparam int DEPTH = 4;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              in_valid = 0, in_ready, rf_en = 0;
  logic [XLEN-1:0]   opr_res = 0, lsu_rdata = 0, pc4 = 0;
  logic [4:0]        rd = 0;
  logic [1:0]        wb_sel = 0, lsu_off = 0;
  logic [2:0]        lsu_op = 0;
  logic [NL-1:0]     late_valid = 0, late_ready;
  logic [NL*XLEN-1:0] late_data = 0;
  logic [NL*5-1:0]   late_rd = 0;
  logic              rf_we, wb_src_late;
  logic [4:0]        rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  wb_stage_arb #(.XLEN(XLEN), .NUM_LATE(NL), .DEPTH(DEPTH), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opr_res(opr_res), .lsu_rdata(lsu_rdata), .pc4(pc4), .rd(rd), .rf_en(rf_en),
    .wb_sel(wb_sel), .lsu_op(lsu_op), .lsu_off(lsu_off),
    .late_valid(late_valid), .late_ready(late_ready), .late_data(late_data), .late_rd(late_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_src_late(wb_src_late)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t m_q[$];
  int   m_rr = 0, m_starve = 0, m_grant;
  logic m_in_ready, m_main_wr, m_we = 0, m_src = 0;
  logic [4:0]  m_wa = 0;
  logic [31:0] m_wd = 0;
  logic        ir_seen;
  logic [NL-1:0] lr_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] op, input logic [1:0] off);
`ifdef WB_LOAD_ALIGN_EN
    longint v;
    v = longint'(w) / (longint'(1) << (8 * off));
    case (op)
      3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return 32'(v);
`else
    return w;
`endif
  endfunction

  function automatic logic [31:0] main_val();
    case (wb_sel)
      2'd1:    return ref_load(lsu_rdata, lsu_op, lsu_off);
      2'd2:    return pc4;
      default: return opr_res;
    endcase
  endfunction

  // One clock of stimulus: check combinational handshakes, clock, then check registered outputs.
  task automatic cycle();
    ent_t e;
    int sz;
    logic pop;
    logic [31:0] exp_lr;
    #1;
    m_in_ready = (m_starve != SL);
    m_main_wr  = in_valid && m_in_ready && rf_en && (rd != 0);
    m_grant    = -1;
    if (m_q.size() < DEPTH)
      for (int k = 0; k < NL; k++) begin
        int c;
        c = (m_rr + k) % NL;
        if (m_grant < 0 && late_valid[c]) m_grant = c;
      end
    exp_lr  = (m_grant >= 0) ? (32'd1 << m_grant) : 32'd0;
    ir_seen = in_ready;
    lr_seen = late_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    chk("late_ready", {30'd0, late_ready}, exp_lr);
    @(posedge clk);
    sz  = m_q.size();
    pop = (sz != 0) && !m_main_wr;
    if (m_main_wr) begin
      m_we = 1; m_wa = rd; m_wd = main_val(); m_src = 0;
    end else if (pop) begin
      e = m_q.pop_front();
      m_we = 1; m_wa = e.rd; m_wd = e.data; m_src = 1;
    end else begin
      m_we = 0; m_src = 0;
    end
    m_starve = (sz != 0 && !pop) ? m_starve + 1 : 0;
    if (m_grant >= 0) begin
      if (late_rd[m_grant*5 +: 5] != 0) begin
        e.rd = late_rd[m_grant*5 +: 5];
        e.data = late_data[m_grant*XLEN +: XLEN];
        m_q.push_back(e);
      end
      m_rr = (m_grant + 1) % NL;
    end
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_we});
    chk("wb_src_late", {31'd0, wb_src_late}, {31'd0, m_src});
    if (m_we) begin
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_wa});
      chk("rf_wdata", rf_wdata, m_wd);
    end
    if (rf_we) $display("wb: src_late=%0d rd=%0d data=0x%08h", wb_src_late, rf_waddr, rf_wdata);
  endtask

  task automatic do_reset();
    late_valid = '1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("rst_wdata", rf_wdata, 32'd0);
    chk("rst_src", {31'd0, wb_src_late}, 32'd0);
    chk("rst_late_ready", {30'd0, late_ready}, 32'd0);
    in_valid = 0; late_valid = 0;
    @(posedge clk); #1;
    chk("rst_hold_we", {31'd0, rf_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_q.delete(); m_rr = 0; m_starve = 0; m_we = 0; m_src = 0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic rf_en; logic [4:0] rd; logic [1:0] wb_sel; logic [2:0] op; logic [1:0] off;
    logic [31:0] opr; logic [31:0] pc; logic e_we; logic [4:0] e_wa; logic [31:0] e_wd;
  } vec_t;
  vec_t tbl[11];

`ifdef WB_LOAD_ALIGN_EN
  localparam logic [31:0] E_LB = 32'hFFFFFF80, E_LBU = 32'h00000080, E_LH = 32'hFFFF80FF;
  localparam logic [31:0] E_LHU0 = 32'h00007F01, E_LHU2 = 32'h000080FF;
`else
  localparam logic [31:0] E_LB = 32'h80FF7F01, E_LBU = 32'h80FF7F01, E_LH = 32'h80FF7F01;
  localparam logic [31:0] E_LHU0 = 32'h80FF7F01, E_LHU2 = 32'h80FF7F01;
`endif

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int lows, low_at;
    logic [1:0] rr_exp [4];
    int ops [5];
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    ops = '{0, 1, 2, 4, 5};

    tbl[0]  = '{1, 5'd5,  2'd0, 3'd0, 2'd0, 32'h00001234, 32'h0, 1, 5'd5,  32'h00001234};
    tbl[1]  = '{1, 5'd0,  2'd0, 3'd0, 2'd0, 32'h00005555, 32'h0, 0, 5'd0,  32'h0};
    tbl[2]  = '{0, 5'd6,  2'd0, 3'd0, 2'd0, 32'h00006666, 32'h0, 0, 5'd0,  32'h0};
    tbl[3]  = '{1, 5'd7,  2'd2, 3'd0, 2'd0, 32'hAAAA0000, 32'h00000104, 1, 5'd7, 32'h00000104};
    tbl[4]  = '{1, 5'd8,  2'd3, 3'd0, 2'd0, 32'hDEADBEEF, 32'h0, 1, 5'd8,  32'hDEADBEEF};
    tbl[5]  = '{1, 5'd9,  2'd1, 3'd0, 2'd3, 32'h0, 32'h0, 1, 5'd9,  E_LB};
    tbl[6]  = '{1, 5'd10, 2'd1, 3'd4, 2'd3, 32'h0, 32'h0, 1, 5'd10, E_LBU};
    tbl[7]  = '{1, 5'd11, 2'd1, 3'd1, 2'd2, 32'h0, 32'h0, 1, 5'd11, E_LH};
    tbl[8]  = '{1, 5'd12, 2'd1, 3'd2, 2'd0, 32'h0, 32'h0, 1, 5'd12, 32'h80FF7F01};
    tbl[9]  = '{1, 5'd13, 2'd1, 3'd5, 2'd0, 32'h0, 32'h0, 1, 5'd13, E_LHU0};
    tbl[10] = '{1, 5'd31, 2'd1, 3'd5, 2'd2, 32'h0, 32'h0, 1, 5'd31, E_LHU2};

    @(posedge clk); #1;
    do_reset();

    // Main-path vectors
    lsu_rdata = 32'h80FF7F01;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1; rf_en = tbl[i].rf_en; rd = tbl[i].rd; wb_sel = tbl[i].wb_sel;
      lsu_op = tbl[i].op; lsu_off = tbl[i].off; opr_res = tbl[i].opr; pc4 = tbl[i].pc;
      cycle();
      chk($sformatf("tbl%0d_we", i), {31'd0, rf_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk($sformatf("tbl%0d_waddr", i), {27'd0, rf_waddr}, {27'd0, tbl[i].e_wa});
        chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].e_wd);
      end
    end

    // x0 suppression with a simultaneous late push
    do_reset();
    in_valid = 1; rf_en = 1; rd = 0; wb_sel = 0; opr_res = 32'h77;
    late_valid = 2'b01; late_rd = {5'd0, 5'd7}; late_data = {32'h0, 32'h000000AA};
    cycle();
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    in_valid = 0; late_valid = 0;
    cycle();
    chk("x0_late_we", {31'd0, rf_we}, 32'd1);
    chk("x0_late_waddr", {27'd0, rf_waddr}, 32'd7);
    chk("x0_late_wdata", rf_wdata, 32'hAA);
    chk("x0_late_src", {31'd0, wb_src_late}, 32'd1);

    // Round-robin with main idle, then fill the FIFO by main-writing every cycle
    do_reset();
    late_valid = 2'b11; late_rd = {5'd3, 5'd2}; late_data = {32'h22220000, 32'h11110000};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk($sformatf("rr_grant%0d", i), {30'd0, lr_seen}, {30'd0, rr_exp[i]});
    end
    in_valid = 1; rf_en = 1; wb_sel = 0;
    for (int i = 0; i < 6; i++) begin
      rd = 5'(i + 1); opr_res = 32'(i);
      cycle();
    end
    chk("full_late_ready", {30'd0, lr_seen}, 32'd0);

    // Starvation guard with one pending entry
    do_reset();
    in_valid = 1; rf_en = 1; rd = 1; wb_sel = 0; opr_res = 32'h1;
    late_valid = 2'b10; late_rd = {5'd9, 5'd0}; late_data = {32'h00005A5A, 32'h0};
    cycle();
    late_valid = 0;
    lows = 0; low_at = -1;
    for (int i = 0; i < 12; i++) begin
      rd = 5'((i % 30) + 2); opr_res = 32'(100 + i);
      cycle();
      if (!ir_seen) begin
        lows++; low_at = i;
        chk("starve_src", {31'd0, wb_src_late}, 32'd1);
        chk("starve_waddr", {27'd0, rf_waddr}, 32'd9);
        chk("starve_wdata", rf_wdata, 32'h5A5A);
      end
    end
    chk("starve_low_cycles", 32'(lows), 32'd1);
    chk("starve_low_at", 32'(low_at), 32'd8);

    // Reset with three entries pending
    do_reset();
    in_valid = 1; rf_en = 1; wb_sel = 0; late_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      rd = 5'(20 + i); opr_res = 32'(i); late_rd = {5'd0, 5'(3 + i)}; late_data = {32'h0, 32'(32'hC0 + i)};
      cycle();
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("post_rst_idle_we", {31'd0, rf_we}, 32'd0);
    end
    late_valid = 2'b11; late_rd = {5'd4, 5'd3};
    cycle();
    chk("rr_restart", {30'd0, lr_seen}, 32'd1);
    late_valid = 0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      rf_en      = ($urandom % 5) != 0;
      rd         = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      wb_sel     = 2'($urandom % 4);
      lsu_op     = 3'(ops[$urandom % 5]);
      lsu_off    = (lsu_op == 3'd2) ? 2'd0 :
                   (lsu_op == 3'd1 || lsu_op == 3'd5) ? 2'(($urandom % 2) * 2) : 2'($urandom % 4);
      opr_res    = $urandom; lsu_rdata = $urandom; pc4 = $urandom;
      late_valid = 2'($urandom % 4);
      for (int c = 0; c < NL; c++) begin
        late_rd[c*5 +: 5]         = (($urandom % 6) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        late_data[c*XLEN +: XLEN] = $urandom;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_stage_arb.md
# wb_stage_arb

Parametrised writeback stage. It merges the in-order pipeline result with up to NUM_LATE out-of-order late producers (muldiv, non-blocking LSU, ...) onto the single register-file write port. It sits between the MEM/WB pipeline register and the register file. It adds four things the fixed single-source writeback does not have: a late-result buffer, round-robin arbitration, a starvation guard, and optional load alignment/sign-extension.

## Interface
Parameters:
- XLEN, 32, datapath width.
- NUM_LATE, 2, number of late-producer channels (≥1).
- DEPTH, 4, late-result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 8, cycles the FIFO head may wait before the main pipeline is throttled (≥1).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  main result present.
- in_ready  out  1  main result consumed this cycle.
- opr_res  in  XLEN  ALU result.
- lsu_rdata  in  XLEN  raw load word.
- pc4  in  XLEN  PC+4 for jal/jalr.
- rd  in  5  destination register.
- rf_en  in  1  main result writes the register file.
- wb_sel  in  2  data select: 0 = opr_res, 1 = load data, 2 = pc4, 3 = opr_res.
- lsu_op  in  3  load type, funct3 encoding (LB, LH, LW, LBU, LHU).
- lsu_off  in  2  byte offset of the load address.
- late_valid  in  NUM_LATE  per-channel result valid.
- late_ready  out  NUM_LATE  per-channel accept.
- late_data  in  NUM_LATE*XLEN  per-channel result, channel i at [i*XLEN +: XLEN].
- late_rd  in  NUM_LATE*5  per-channel destination.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  write address (registered).
- rf_wdata  out  XLEN  write data (registered).
- wb_src_late  out  1  current write comes from the FIFO (registered).

## Operation
- **Main path.** A main transfer happens when in_valid && in_ready. It is a "main write" if rf_en && rd != 0. Writes to x0 are always suppressed.
- **Late channels.**
  - At most one late channel is granted per cycle, and only when the FIFO is not full.
  - Arbitration is round-robin. The search starts at rr_ptr; the first channel with late_valid is granted and its late_ready is asserted.
  - After a grant, rr_ptr = (granted+1) mod NUM_LATE. rr_ptr resets to 0.
  - A granted entry with late_rd = 0 is accepted but not pushed.
- **FIFO.**
  - Holds {rd, data}.
  - Pops exactly when the FIFO is not empty and no main write occurs this cycle. A non-writing main transfer (rf_en = 0 or rd = 0) may complete in the same cycle as a pop.
- **Starvation guard.**
  - starve_cnt increments each cycle the FIFO is non-empty and does not pop.
  - It clears on a pop or when the FIFO is empty.
  - When starve_cnt == STARVE_LIMIT, in_ready = 0 for that cycle, which forces a pop.
  - Otherwise in_ready = 1.
- **Priority.** Main write > FIFO pop. Only one register-file write occurs per cycle.
- **Full FIFO.** late_ready is all-zero while the FIFO is full. Push and pop are not combined when full: fullness is evaluated on the current count.
- **Ordering.** The issue stage guarantees no WAW overlap between main and late destinations. This block does not reorder within the FIFO.
- **Reset.**
  - rst_n low clears the FIFO (contents discarded), rr_ptr, starve_cnt and all outputs.
  - late_ready is forced to 0 while rst_n is low.

## Timing
- Main write: accepted at cycle N → rf_we/rf_waddr/rf_wdata valid at N+1.
- Late result: pushed at N → earliest pop at N+1 → write visible at N+2. There is no bypass from push to output.
- Guard: if the main path writes every cycle, a non-empty FIFO's head is written at most STARVE_LIMIT+2 cycles after it reaches the head.
- Reset values: rf_we = 0, rf_waddr = 0, rf_wdata = 0, wb_src_late = 0.
- in_ready and late_ready are combinational from state and inputs; rf_* outputs are registered.

## Configuration
- WB_LOAD_ALIGN_EN defined:
  - When wb_sel = 1, load data = lsu_rdata shifted right by 8*lsu_off, then sign- or zero-extended per lsu_op.
  - LB/LBU take byte [7:0]. LH/LHU take half [15:0] and require lsu_off[0] = 0. LW uses the full word.
- Undefined: lsu_rdata passes through unchanged; lsu_op and lsu_off are ignored.

## Test plan
- **Main write.** Main write rd=5, wb_sel=0, opr_res=0x1234 at cycle N → rf_we=1, rf_waddr=5, rf_wdata=0x1234 at N+1.
- **x0 suppression.** Main write with rd=0 → rf_we=0. Simultaneous late_valid[0] with rd=7, data=0xAA → written at N+2 with wb_src_late=1.
- **Round-robin and full FIFO.** Both late channels held valid continuously (DEPTH=4), main idle → grants alternate 0,1,0,1. Then stall the drain by main-writing every cycle → late_ready=0 once count=4.
- **Starvation.** Main writes every cycle with one FIFO entry pending (STARVE_LIMIT=8) → in_ready drops for exactly one cycle, 8 cycles after the entry reaches the head, and the entry is written the next cycle.
- **Load alignment.** WB_LOAD_ALIGN_EN, lsu_rdata=0x80FF7F01:
  - LB, off=3 → 0xFFFFFF80.
  - LBU, off=3 → 0x00000080.
  - LH, off=2 → 0xFFFF80FF.
  - Without the macro → 0x80FF7F01.
- **Reset mid-operation.** Assert rst_n low with 3 FIFO entries pending → all outputs 0 and late_ready=0 during reset. After release there are no writes until new input, and rr_ptr restarts at 0.
